pc_ctrl: RTL and testbench

//  Sequencing control unit for the picoMIPS core. It is the driving end of the program-counter control interface.

---
 rtl/pc_ctrl_if.sv | 24 ++
 rtl/pc_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_pc_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_if.sv
// Program-counter control bus between the sequencer (master) and the pc register (slave).
// Only one of the three strobes is active in any cycle.
interface pc_ctrl_if #(
  parameter int Psize = 5
);
  logic             PCincr;
  logic             PCabsbranch;
  logic             PCrelbranch;
  logic [Psize-1:0] Branchaddr;

  modport master (
    output PCincr,
    output PCabsbranch,
    output PCrelbranch,
    output Branchaddr
  );

  modport slave (
    input PCincr,
    input PCabsbranch,
    input PCrelbranch,
    input Branchaddr
  );
endinterface

// File: rtl/pc_ctrl.sv
// picoMIPS sequencing control: decodes the fetched instruction into pc strobes and datapath
// controls; a small FSM covers multi-cycle multiply, switch-handshake waits and halt.
module pc_ctrl #(
  parameter int Psize     = 5,
  parameter int Isize     = 20,
  parameter int MulCycles = 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [Isize-1:0] Instr,
  input  logic             Zflag,
  input  logic             SW8,
  pc_ctrl_if.master        pc_bus,
  output logic             RegWE,
  output logic             ImmSel,
  output logic [2:0]       ALUfunc,
  output logic             Halted
);

  localparam int CW = $clog2(MulCycles) + 1;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_MULI  = 4'h4;
  localparam logic [3:0] OP_BEQ   = 4'h5;
  localparam logic [3:0] OP_BNE   = 4'h6;
  localparam logic [3:0] OP_J     = 4'h7;
  localparam logic [3:0] OP_WAITH = 4'h8;
  localparam logic [3:0] OP_WAITL = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_MUL  = 3'b011;

  typedef enum logic [1:0] {
    EXEC     = 2'd0,
    MUL_WAIT = 2'd1,
    WAIT_SW  = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   mulcnt_q, mulcnt_d;
  logic            sw_meta_q, sw_meta_d;
  logic            sw_sync_q, sw_sync_d;

  logic [3:0]      opcode_s;
  logic            sw_s;
  logic            pcincr_s, pcabs_s, pcrel_s, regwe_s, immsel_s, halted_s;
  logic [2:0]      alufunc_s;
  logic            unused_instr_s;

  assign opcode_s       = Instr[Isize-1:Isize-4];
  assign sw_s           = sw_sync_q;
  assign unused_instr_s = ^Instr[Isize-5:Psize];

  // Two-flop synchroniser for the asynchronous handshake switch.
  always_comb begin
    sw_meta_d = SW8;
    sw_sync_d = sw_meta_q;
  end

  // State, multiply counter and synchroniser registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= EXEC;
      mulcnt_q  <= {CW{1'b0}};
      sw_meta_q <= 1'b0;
      sw_sync_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mulcnt_q  <= mulcnt_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d   = state_q;
    mulcnt_d  = mulcnt_q;
    pcincr_s  = 1'b0;
    pcabs_s   = 1'b0;
    pcrel_s   = 1'b0;
    regwe_s   = 1'b0;
    immsel_s  = 1'b0;
    halted_s  = 1'b0;
    alufunc_s = ALU_PASS;

    case (state_q)
      EXEC: begin
        case (opcode_s)
          OP_NOP: begin
            pcincr_s = 1'b1;
          end
          OP_ADD: begin
            regwe_s   = 1'b1;
            pcincr_s  = 1'b1;
            alufunc_s = ALU_ADD;
          end
          OP_ADDI: begin
            regwe_s   = 1'b1;
            pcincr_s  = 1'b1;
            immsel_s  = 1'b1;
            alufunc_s = ALU_ADD;
          end
          OP_SUB: begin
            regwe_s   = 1'b1;
            pcincr_s  = 1'b1;
            alufunc_s = ALU_SUB;
          end
          OP_MULI: begin
            alufunc_s = ALU_MUL;
            immsel_s  = 1'b1;
            state_d   = MUL_WAIT;
            mulcnt_d  = CW'(1);
          end
          OP_BEQ: begin
            if (Zflag) begin
              pcrel_s = 1'b1;
            end else begin
              pcincr_s = 1'b1;
            end
          end
          OP_BNE: begin
            if (Zflag) begin
              pcincr_s = 1'b1;
            end else begin
              pcrel_s = 1'b1;
            end
          end
          OP_J: begin
            pcabs_s = 1'b1;
          end
          OP_WAITH: begin
            if (sw_s) begin
              pcincr_s = 1'b1;
            end else begin
              state_d = WAIT_SW;
            end
          end
          OP_WAITL: begin
            if (!sw_s) begin
              pcincr_s = 1'b1;
            end else begin
              state_d = WAIT_SW;
            end
          end
          OP_HALT: begin
            state_d = HALT;
          end
          default: begin
            pcincr_s = 1'b1;
          end
        endcase
      end

      MUL_WAIT: begin
        alufunc_s = ALU_MUL;
        immsel_s  = 1'b1;
        if (mulcnt_q == CW'(MulCycles - 1)) begin
          regwe_s  = 1'b1;
          pcincr_s = 1'b1;
          state_d  = EXEC;
          mulcnt_d = {CW{1'b0}};
        end else begin
          mulcnt_d = mulcnt_q + CW'(1);
        end
      end

      // The wait instruction is still on Instr, so its opcode gives the polarity to wait for.
      WAIT_SW: begin
        if (sw_s == (opcode_s == OP_WAITH)) begin
          pcincr_s = 1'b1;
          state_d  = EXEC;
        end else begin
          state_d = WAIT_SW;
        end
      end

      HALT: begin
        halted_s = 1'b1;
      end

      default: begin
        state_d = EXEC;
      end
    endcase
  end

  // Everything is forced low while reset is held, independent of the decoded instruction.
  assign pc_bus.PCincr      = nreset & pcincr_s;
  assign pc_bus.PCabsbranch = nreset & pcabs_s;
  assign pc_bus.PCrelbranch = nreset & pcrel_s;
  assign pc_bus.Branchaddr  = nreset ? Instr[Psize-1:0] : {Psize{1'b0}};
  assign RegWE              = nreset & regwe_s;
  assign ImmSel             = nreset & immsel_s;
  assign ALUfunc            = nreset ? alufunc_s : 3'b000;
  assign Halted             = nreset & halted_s;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: each stimulus cycle queues the hand-computed output vector,
// and a monitor pops and compares it mid-cycle, away from the rising edge.
module tb_pc_ctrl;

  logic        clk;
  logic        nreset;
  logic [19:0] instr;
  logic        zflag;
  logic        sw8;
  logic        regwe, immsel, halted;
  logic [2:0]  alufunc;

  pc_ctrl_if #(.Psize(5)) pcb ();

  pc_ctrl #(.Psize(5), .Isize(20), .MulCycles(2)) dut (
    .clk     (clk),
    .nreset  (nreset),
    .Instr   (instr),
    .Zflag   (zflag),
    .SW8     (sw8),
    .pc_bus  (pcb.master),
    .RegWE   (regwe),
    .ImmSel  (immsel),
    .ALUfunc (alufunc),
    .Halted  (halted)
  );

  typedef struct {
    string       nm;
    logic [13:0] v;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  logic [13:0] act;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {Halted, RegWE, ImmSel, ALUfunc, PCincr, PCabsbranch, PCrelbranch, Branchaddr}
  function automatic logic [13:0] ev(input logic h, input logic we, input logic imm,
                                     input logic [2:0] alu, input logic inc, input logic ab,
                                     input logic rl, input logic [4:0] ba);
    return {h, we, imm, alu, inc, ab, rl, ba};
  endfunction

  function automatic logic [19:0] mk(input logic [3:0] op, input logic [4:0] a);
    return {op, 11'd0, a};
  endfunction

  task automatic step(input string nm, input logic rst_v, input logic sw_v,
                      input logic [19:0] ins, input logic z, input logic [13:0] e);
    @(negedge clk);
    nreset = rst_v;
    sw8    = sw_v;
    instr  = ins;
    zflag  = z;
    sb.push_back('{nm, e});
  endtask

  // Monitor: compares the queued expectation against the DUT outputs mid-cycle.
  always @(negedge clk) begin
    #2;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      act = {halted, regwe, immsel, alufunc, pcb.PCincr, pcb.PCabsbranch, pcb.PCrelbranch,
             pcb.Branchaddr};
      checks = checks + 1;
      if (act !== cur.v) begin
        errors = errors + 1;
        $display("FAIL %s: got %b expected %b", cur.nm, act, cur.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  localparam logic [13:0] Z0 = 14'd0;

  initial begin
    nreset = 1'b0;
    sw8    = 1'b0;
    instr  = 20'd0;
    zflag  = 1'b0;

    step("reset_hold0", 1'b0, 1'b0, mk(4'h0, 5'd0), 1'b0, Z0);
    step("reset_hold1", 1'b0, 1'b0, mk(4'h7, 5'd9), 1'b1, Z0);

    for (int i = 0; i < 3; i++)
      step("nop_after_reset", 1'b1, 1'b0, mk(4'h0, 5'd0), 1'b0,
           ev(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0));

    step("beq_taken",    1'b1, 1'b0, mk(4'h5, 5'b00011), 1'b1,
         ev(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 5'b00011));
    step("beq_nottaken", 1'b1, 1'b0, mk(4'h5, 5'b00011), 1'b0,
         ev(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'b00011));
    step("bne_taken",    1'b1, 1'b0, mk(4'h6, 5'b11110), 1'b0,
         ev(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 5'b11110));
    step("bne_nottaken", 1'b1, 1'b0, mk(4'h6, 5'b11110), 1'b1,
         ev(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'b11110));
    step("jump",         1'b1, 1'b0, mk(4'h7, 5'b00010), 1'b0,
         ev(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 5'b00010));
    step("addi",         1'b1, 1'b0, mk(4'h2, 5'b00100), 1'b0,
         ev(1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 5'b00100));
    step("add",          1'b1, 1'b0, mk(4'h1, 5'b00000), 1'b1,
         ev(1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 5'b00000));
    step("sub",          1'b1, 1'b0, mk(4'h3, 5'b00001), 1'b0,
         ev(1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 5'b00001));
    step("op_c_as_nop",  1'b1, 1'b0, mk(4'hC, 5'b10101), 1'b0,
         ev(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'b10101));

    step("muli_c0", 1'b1, 1'b0, mk(4'h4, 5'd1), 1'b0,
         ev(1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 5'd1));
    step("muli_c1", 1'b1, 1'b0, mk(4'h4, 5'd1), 1'b0,
         ev(1'b0, 1'b1, 1'b1, 3'b011, 1'b1, 1'b0, 1'b0, 5'd1));
    step("nop_after_muli", 1'b1, 1'b0, mk(4'h0, 5'd0), 1'b0,
         ev(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0));

    // WAITH with switch low stalls; the raised switch shows up after two rising edges.
    for (int i = 0; i < 5; i++)
      step("waith_stall", 1'b1, 1'b0, mk(4'h8, 5'd0), 1'b0, Z0 | 14'd0);
    step("waith_raise",  1'b1, 1'b1, mk(4'h8, 5'd0), 1'b0, Z0);
    step("waith_sync1",  1'b1, 1'b1, mk(4'h8, 5'd0), 1'b0, Z0);
    step("waith_go",     1'b1, 1'b1, mk(4'h8, 5'd0), 1'b0,
         ev(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0));
    step("nop_after_waith", 1'b1, 1'b1, mk(4'h0, 5'd0), 1'b0,
         ev(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0));
    step("waith_sw_high", 1'b1, 1'b1, mk(4'h8, 5'd0), 1'b0,
         ev(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0));
    step("waitl_stall",  1'b1, 1'b1, mk(4'h9, 5'd0), 1'b0, Z0);
    step("waitl_drop",   1'b1, 1'b0, mk(4'h9, 5'd0), 1'b0, Z0);
    step("waitl_sync1",  1'b1, 1'b0, mk(4'h9, 5'd0), 1'b0, Z0);
    step("waitl_go",     1'b1, 1'b0, mk(4'h9, 5'd0), 1'b0,
         ev(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0));

    // Reset in the middle of a multiply must suppress its register write.
    step("muli2_c0", 1'b1, 1'b0, mk(4'h4, 5'd3), 1'b0,
         ev(1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 5'd3));
    step("rst_in_mulwait", 1'b0, 1'b0, mk(4'h4, 5'd3), 1'b0, Z0);
    step("rst_hold_mul",   1'b0, 1'b0, mk(4'h4, 5'd3), 1'b0, Z0);
    step("nop_after_mulrst", 1'b1, 1'b0, mk(4'h0, 5'd0), 1'b0,
         ev(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0));

    step("halt_issue", 1'b1, 1'b0, mk(4'hF, 5'd0), 1'b0, Z0);
    step("halted0",    1'b1, 1'b0, mk(4'h0, 5'd0), 1'b0,
         ev(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0));
    step("halted1",    1'b1, 1'b0, mk(4'h7, 5'd6), 1'b1,
         ev(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd6));
    step("rst_in_halt", 1'b0, 1'b0, mk(4'h0, 5'd0), 1'b0, Z0);
    step("nop_after_haltrst", 1'b1, 1'b0, mk(4'h0, 5'd0), 1'b0,
         ev(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0));

    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(negedge clk);
    repeat (2) @(negedge clk);
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
